// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: step controls in, count and flags out.
// The sat flag exists only when MOD_UPDOWN_COUNTER_SATURATE_EN is defined.
interface mod_updown_counter_if #(
  parameter int WIDTH = 6
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
  logic             sat;

  modport master (output en, up, load, load_value, input count, tc, wrap, sat);
  modport slave  (input en, up, load, load_value, output count, tc, wrap, sat);
`else
  modport master (output en, up, load, load_value, input count, tc, wrap);
  modport slave  (input en, up, load, load_value, output count, tc, wrap);
`endif
endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-(MAX+1) up/down counter with parallel load, terminal count and wrap pulse.
// Optional build macro MOD_UPDOWN_COUNTER_SATURATE_EN turns wrapping into saturation and adds sat.
module mod_updown_counter #(
  parameter int WIDTH       = 6,
  parameter int MAX         = 63,
  parameter int RESET_VALUE = 0
) (
  input logic                 clock,
  input logic                 clear,
  mod_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_p0;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_zero;
  logic             at_end;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
  logic             sat_p0;
  logic             sat_nxt;
`endif

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
    return (value > MAX_V) ? MAX_V : value;
  endfunction

  // Wraps within [0, MAX] rather than at 2^WIDTH.
  function automatic logic [WIDTH-1:0] step_mod(input logic [WIDTH-1:0] cur, input logic dir_up);
    if (dir_up) begin
      return (cur == MAX_V) ? '0 : cur + ONE;
    end
    return (cur == '0) ? MAX_V : cur - ONE;
  endfunction

  assign at_max  = (count_p0 == MAX_V);
  assign at_zero = (count_p0 == '0);
  assign at_end  = (bus.up & at_max) | (~bus.up & at_zero);

  assign bus.tc    = bus.en & at_end;
  assign bus.count = count_p0;
  assign bus.wrap  = wrap_p0;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
  assign bus.sat   = sat_p0;
`endif

  always_comb begin
    count_nxt = count_p0;
    wrap_nxt  = 1'b0;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
    sat_nxt   = sat_p0;
`endif
    if (bus.load) begin
      count_nxt = clamp_load(bus.load_value);
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
      sat_nxt   = 1'b0;
`endif
    end else if (bus.en) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
      if (at_end) begin
        sat_nxt   = 1'b1;
      end else begin
        count_nxt = step_mod(count_p0, bus.up);
        sat_nxt   = 1'b0;
      end
`else
      count_nxt = step_mod(count_p0, bus.up);
      wrap_nxt  = at_end;
`endif
    end
  end

  // Registered state: count, wrap pulse (and saturation flag).
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_p0 <= RESET_V;
      wrap_p0  <= 1'b0;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
      sat_p0   <= 1'b0;
`endif
    end else begin
      count_p0 <= count_nxt;
      wrap_p0  <= wrap_nxt;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
      sat_p0   <= sat_nxt;
`endif
    end
  end

endmodule
